// File: rtl/iodelay_tap_loader_if.sv
// Tap-load request and completion bundle between the config/CSR side
// and the IDELAYE2 tap loader.
interface iodelay_tap_loader_if #(
    parameter int num_lanes_p = 5,
    parameter int tap_width_p = 5
);
    localparam int lane_w_lp = (num_lanes_p > 1) ? $clog2(num_lanes_p) : 1;

    logic                   v_i;
    logic [lane_w_lp-1:0]   lane_i;
    logic [tap_width_p-1:0] tap_i;
    logic                   ready_o;
    logic                   done_v_o;
    logic [lane_w_lp-1:0]   done_lane_o;
    logic                   done_err_o;

    modport master (
        output v_i, lane_i, tap_i,
        input  ready_o, done_v_o, done_lane_o, done_err_o
    );

    modport slave (
        input  v_i, lane_i, tap_i,
        output ready_o, done_v_o, done_lane_o, done_err_o
    );
endinterface

// File: rtl/iodelay_tap_loader.sv
// Sequences VAR_LOAD tap loads into the RGMII RX IDELAYE2 cells. Keeps a
// shadow tap per lane, replays every shadow after IDELAYCTRL RDY rises,
// then serves single-lane tap changes, verifying each via CNTVALUEOUT.
module iodelay_tap_loader #(
    parameter int num_lanes_p     = 5,
    parameter int tap_width_p     = 5,
    parameter int settle_cycles_p = 4,
    parameter int init_tap_p      = 0
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               idelayctrl_rdy_i,
    iodelay_tap_loader_if.slave                req_if,
    output logic                               init_done_o,
    output logic                               cal_err_o,
    output logic [num_lanes_p-1:0]             idelay_ld_o,
    output logic [tap_width_p-1:0]             idelay_cntvalue_o,
    input  logic [num_lanes_p*tap_width_p-1:0] idelay_cntvalue_i
);
    localparam int LANE_W = (num_lanes_p > 1) ? $clog2(num_lanes_p) : 1;
    localparam int CNT_W  = (settle_cycles_p > 0) ? $clog2(settle_cycles_p + 1) : 1;

    typedef enum logic [2:0] {
        S_WAIT_RDY,
        S_INIT_LOAD,
        S_INIT_SETTLE,
        S_INIT_CHECK,
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CHECK
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_rdy_meta;
    logic                   r_rdy_s;
    logic [LANE_W-1:0]      r_ptr;
    logic [LANE_W-1:0]      r_lane;
    logic [tap_width_p-1:0] r_tap;
    logic [CNT_W-1:0]       r_cnt;
    logic [tap_width_p-1:0] r_cntvalue;
    logic [tap_width_p-1:0] r_shadow [num_lanes_p];
    logic                   r_done_v;
    logic [LANE_W-1:0]      r_done_lane;
    logic                   r_done_err;
    logic                   r_init_done;
    logic                   r_cal_err;

    logic                   w_in_init;
    logic [LANE_W-1:0]      w_sel_lane;
    logic [LANE_W-1:0]      w_ptr_inc;
    logic [tap_width_p-1:0] w_readback;
    logic [tap_width_p-1:0] w_shadow_ptr;
    logic [tap_width_p-1:0] w_shadow_inc;
    logic [tap_width_p-1:0] w_expect;
    logic                   w_mismatch;
    logic [num_lanes_p-1:0] w_ld;
    logic                   w_ready;

    logic                   w_accept;
    logic                   w_cnt_load;
    logic                   w_ptr_clr;
    logic                   w_ptr_step;
    logic                   w_cntval_ld;
    logic [tap_width_p-1:0] w_cntval_nxt;
    logic                   w_done_set;
    logic                   w_done_err;
    logic [LANE_W-1:0]      w_done_lane;
    logic                   w_commit;
    logic                   w_init_set;
    logic                   w_init_clr;
    logic                   w_cal_set;

    assign w_in_init  = (r_state == S_INIT_LOAD) || (r_state == S_INIT_SETTLE) ||
                        (r_state == S_INIT_CHECK);
    assign w_sel_lane = w_in_init ? r_ptr : r_lane;
    assign w_ptr_inc  = r_ptr + 1'b1;
    assign w_expect   = w_in_init ? w_shadow_ptr : r_tap;
    assign w_mismatch = (w_readback != w_expect);
    assign w_ready    = (r_state == S_IDLE) && r_rdy_s;

    // Lane-indexed lookups: readback, shadow taps and the one-hot LD decode
    always_comb begin
        w_readback   = '0;
        w_shadow_ptr = '0;
        w_shadow_inc = '0;
        w_ld         = '0;
        for (int k = 0; k < num_lanes_p; k++) begin
            if (w_sel_lane == LANE_W'(k)) begin
                w_readback = idelay_cntvalue_i[k*tap_width_p +: tap_width_p];
            end
            if (r_ptr == LANE_W'(k)) begin
                w_shadow_ptr = r_shadow[k];
                if (r_state == S_INIT_LOAD) begin
                    w_ld[k] = 1'b1;
                end
            end
            if (w_ptr_inc == LANE_W'(k)) begin
                w_shadow_inc = r_shadow[k];
            end
            if ((r_lane == LANE_W'(k)) && (r_state == S_LOAD)) begin
                w_ld[k] = 1'b1;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous IDELAYCTRL RDY
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rdy_meta <= 1'b0;
            r_rdy_s    <= 1'b0;
        end else begin
            r_rdy_meta <= idelayctrl_rdy_i;
            r_rdy_s    <= r_rdy_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_WAIT_RDY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and per-cycle control decode; RDY loss overrides everything
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_cnt_load   = 1'b0;
        w_ptr_clr    = 1'b0;
        w_ptr_step   = 1'b0;
        w_cntval_ld  = 1'b0;
        w_cntval_nxt = r_cntvalue;
        w_done_set   = 1'b0;
        w_done_err   = 1'b0;
        w_done_lane  = r_lane;
        w_commit     = 1'b0;
        w_init_set   = 1'b0;
        w_init_clr   = 1'b0;
        w_cal_set    = 1'b0;

        if (!r_rdy_s && (r_state != S_WAIT_RDY)) begin
            w_state_nxt = S_WAIT_RDY;
            w_init_clr  = 1'b1;
            if ((r_state == S_LOAD) || (r_state == S_SETTLE) || (r_state == S_CHECK)) begin
                w_done_set = 1'b1;
                w_done_err = 1'b1;
            end
        end else begin
            case (r_state)
                S_WAIT_RDY: begin
                    if (r_rdy_s) begin
                        w_state_nxt  = S_INIT_LOAD;
                        w_ptr_clr    = 1'b1;
                        w_cntval_ld  = 1'b1;
                        w_cntval_nxt = r_shadow[0];
                    end
                end
                S_INIT_LOAD: begin
                    w_state_nxt = S_INIT_SETTLE;
                    w_cnt_load  = 1'b1;
                end
                S_INIT_SETTLE: begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_INIT_CHECK;
                    end
                end
                S_INIT_CHECK: begin
                    w_cal_set = w_mismatch;
                    if (r_ptr == LANE_W'(num_lanes_p - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_init_set  = 1'b1;
                    end else begin
                        w_state_nxt  = S_INIT_LOAD;
                        w_ptr_step   = 1'b1;
                        w_cntval_ld  = 1'b1;
                        w_cntval_nxt = w_shadow_inc;
                    end
                end
                S_IDLE: begin
                    if (req_if.v_i) begin
                        w_accept = 1'b1;
                        if (int'(req_if.lane_i) >= num_lanes_p) begin
                            w_done_set  = 1'b1;
                            w_done_err  = 1'b1;
                            w_done_lane = req_if.lane_i;
                        end else begin
                            w_state_nxt  = S_LOAD;
                            w_cntval_ld  = 1'b1;
                            w_cntval_nxt = req_if.tap_i;
                        end
                    end
                end
                S_LOAD: begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_load  = 1'b1;
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_CHECK;
                    end
                end
                S_CHECK: begin
                    w_state_nxt = S_IDLE;
                    w_done_set  = 1'b1;
                    w_done_err  = w_mismatch;
                    w_commit    = !w_mismatch;
                end
                default: begin
                    w_state_nxt = S_WAIT_RDY;
                end
            endcase
        end
    end

    // Control registers: lane pointer, settle counter, CNTVALUEIN, status and done pulse
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_cntvalue  <= '0;
            r_done_v    <= 1'b0;
            r_done_lane <= '0;
            r_done_err  <= 1'b0;
            r_init_done <= 1'b0;
            r_cal_err   <= 1'b0;
        end else begin
            if (w_ptr_clr) begin
                r_ptr <= '0;
            end else if (w_ptr_step) begin
                r_ptr <= w_ptr_inc;
            end

            if (w_cnt_load) begin
                r_cnt <= CNT_W'(settle_cycles_p);
            end else if ((r_state == S_SETTLE) || (r_state == S_INIT_SETTLE)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_cntval_ld) begin
                r_cntvalue <= w_cntval_nxt;
            end

            r_done_v <= w_done_set;
            if (w_done_set) begin
                r_done_lane <= w_done_lane;
                r_done_err  <= w_done_err;
            end

            if (w_init_clr) begin
                r_init_done <= 1'b0;
            end else if (w_init_set) begin
                r_init_done <= 1'b1;
            end

            if (w_cal_set) begin
                r_cal_err <= 1'b1;
            end
        end
    end

    // Latched request lane and tap, held through LOAD/SETTLE/CHECK
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_lane <= req_if.lane_i;
            r_tap  <= req_if.tap_i;
        end
    end

    // Shadow taps: reinitialised on reset, updated only by a verified load
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < num_lanes_p; k++) begin
            if (reset_i) begin
                r_shadow[k] <= tap_width_p'(init_tap_p);
            end else if (w_commit && (r_lane == LANE_W'(k))) begin
                r_shadow[k] <= r_tap;
            end
        end
    end

    assign req_if.ready_o     = w_ready;
    assign req_if.done_v_o    = r_done_v;
    assign req_if.done_lane_o = r_done_lane;
    assign req_if.done_err_o  = r_done_err;
    assign init_done_o        = r_init_done;
    assign cal_err_o          = r_cal_err;
    assign idelay_ld_o        = w_ld;
    assign idelay_cntvalue_o  = r_cntvalue;
endmodule

// File: tb/tb_iodelay_tap_loader.sv
// Scoreboard bench for iodelay_tap_loader with a behavioural IDELAYE2 model.
module tb_iodelay_tap_loader;
    localparam int N  = 5;
    localparam int TW = 5;
    localparam int S  = 4;
    localparam int LW = 3;

    logic            clk     = 1'b0;
    logic            reset_i = 1'b1;
    logic            rdy     = 1'b0;
    logic            init_done;
    logic            cal_err;
    logic [N-1:0]    ld;
    logic [TW-1:0]   cntv_o;
    logic [N*TW-1:0] cntv_i;

    logic [TW-1:0]   tap_m   [N];
    logic [N-1:0]    frc_en;
    logic [TW-1:0]   frc_val [N];

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct { int lane; int err; int cyc; } done_t;
    typedef struct { logic [N-1:0] mask; int tap; int cyc; } ld_t;
    done_t done_q[$];
    ld_t   ld_q[$];
    done_t md;
    ld_t   ml;

    always #5 clk = ~clk;

    iodelay_tap_loader_if #(.num_lanes_p(N), .tap_width_p(TW)) req_if ();

    iodelay_tap_loader #(
        .num_lanes_p(N), .tap_width_p(TW), .settle_cycles_p(S), .init_tap_p(0)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .idelayctrl_rdy_i  (rdy),
        .req_if            (req_if),
        .init_done_o       (init_done),
        .cal_err_o         (cal_err),
        .idelay_ld_o       (ld),
        .idelay_cntvalue_o (cntv_o),
        .idelay_cntvalue_i (cntv_i)
    );

    // IDELAYE2 VAR_LOAD model: LD captures CNTVALUEIN; a lane may be forced
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < N; k++) begin
            if (reset_i) tap_m[k] <= '0;
            else if (ld[k]) tap_m[k] <= cntv_o;
        end
    end

    always_comb begin
        cntv_i = '0;
        for (int k = 0; k < N; k++) begin
            cntv_i[k*TW +: TW] = frc_en[k] ? frc_val[k] : tap_m[k];
        end
    end

    function automatic void chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: every LD pulse and every done pulse is matched against the queues
    always @(negedge clk) begin
        if (!reset_i) begin
            if (req_if.done_v_o) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done_lane", int'(req_if.done_lane_o), -1);
                end else begin
                    md = done_q.pop_front();
                    chk("done_lane", int'(req_if.done_lane_o), md.lane);
                    chk("done_err", int'(req_if.done_err_o), md.err);
                    chk("done_cycle", cyc, md.cyc);
                end
            end
            if (ld != '0) begin
                if (ld_q.size() == 0) begin
                    chk("unexpected_ld_mask", int'(ld), 0);
                end else begin
                    ml = ld_q.pop_front();
                    chk("ld_mask", int'(ld), int'(ml.mask));
                    chk("ld_tap", int'(cntv_o), ml.tap);
                    if (ml.cyc >= 0) chk("ld_cycle", cyc, ml.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ld(input int lane, input int tap, input int at);
        ld_t e;
        e.mask       = '0;
        e.mask[lane] = 1'b1;
        e.tap        = tap;
        e.cyc        = at;
        ld_q.push_back(e);
    endtask

    task automatic push_replay(input int t0, input int t1, input int t2, input int t3, input int t4);
        push_ld(0, t0, -1);
        push_ld(1, t1, -1);
        push_ld(2, t2, -1);
        push_ld(3, t3, -1);
        push_ld(4, t4, -1);
    endtask

    // Issue one request; done_off = cycles from acceptance to done (0 = none expected)
    task automatic issue(input int lane, input int tap, input int err, input int done_off);
        int    g;
        int    t;
        done_t d;
        g = 0;
        while (!req_if.ready_o && g < 500) begin
            tick(1);
            g++;
        end
        if (!req_if.ready_o) begin
            n_total++;
            $display("FAIL ready_timeout: ready_o still 0 after %0d cycles", g);
        end else begin
            t = cyc;
            req_if.v_i    = 1'b1;
            req_if.lane_i = lane[LW-1:0];
            req_if.tap_i  = tap[TW-1:0];
            if (lane < N) push_ld(lane, tap, t + 1);
            if (done_off > 0) begin
                d.lane = lane;
                d.err  = err;
                d.cyc  = t + done_off;
                done_q.push_back(d);
            end
            tick(1);
            req_if.v_i = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((done_q.size() != 0 || ld_q.size() != 0) && g < 2000) begin
            tick(1);
            g++;
        end
        if (done_q.size() != 0 || ld_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d done and %0d ld events outstanding",
                     done_q.size(), ld_q.size());
            done_q.delete();
            ld_q.delete();
        end
    endtask

    task automatic wait_init();
        int g;
        g = 0;
        while (!init_done && g < 500) begin
            tick(1);
            g++;
        end
        chk("init_done_reached", int'(init_done), 1);
    endtask

    initial begin
        req_if.v_i    = 1'b0;
        req_if.lane_i = '0;
        req_if.tap_i  = '0;
        frc_en        = '0;
        for (int k = 0; k < N; k++) frc_val[k] = '0;
        rdy = 1'b1;
        tick(3);

        // Reset state
        chk("rst_ready", int'(req_if.ready_o), 0);
        chk("rst_done_v", int'(req_if.done_v_o), 0);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_cal_err", int'(cal_err), 0);
        chk("rst_ld", int'(ld), 0);
        chk("rst_cntvalue", int'(cntv_o), 0);

        // Initial replay of all lanes at tap 0
        push_replay(0, 0, 0, 0, 0);
        reset_i = 1'b0;
        wait_drain();
        wait_init();
        chk("init_cal_err", int'(cal_err), 0);
        chk("init_ready", int'(req_if.ready_o), 1);

        // Good load: lane 2 tap 17
        issue(2, 17, 0, 3 + S);
        wait_drain();

        // Readback mismatch: lane 1 tap 9 reads back 8, shadow stays 0
        frc_en[1]  = 1'b1;
        frc_val[1] = 5'd8;
        issue(1, 9, 1, 3 + S);
        wait_drain();
        frc_en[1] = 1'b0;
        rdy = 1'b0;
        tick(4);
        chk("rdydrop_init_done", int'(init_done), 0);
        chk("rdydrop_ready", int'(req_if.ready_o), 0);
        push_replay(0, 0, 17, 0, 0);
        rdy = 1'b1;
        wait_drain();
        wait_init();
        chk("replay1_cal_err", int'(cal_err), 0);

        // Out-of-range lane: immediate error completion, ready stays up
        issue(6, 3, 1, 1);
        chk("badlane_ready", int'(req_if.ready_o), 1);
        wait_drain();

        // RDY lost during SETTLE of lane 3
        issue(3, 5, 1, 4);
        rdy = 1'b0;
        tick(6);
        chk("abort_init_done", int'(init_done), 0);
        chk("abort_ready", int'(req_if.ready_o), 0);
        wait_drain();
        push_replay(0, 0, 17, 0, 0);
        rdy = 1'b1;
        tick(3);
        chk("replay2_ready_low", int'(req_if.ready_o), 0);
        wait_drain();
        wait_init();
        chk("replay2_ready", int'(req_if.ready_o), 1);

        // Replay mismatch on lane 0 makes cal_err sticky
        frc_en[0]  = 1'b1;
        frc_val[0] = 5'd3;
        rdy = 1'b0;
        tick(4);
        push_replay(0, 0, 17, 0, 0);
        rdy = 1'b1;
        wait_drain();
        wait_init();
        chk("replay3_cal_err", int'(cal_err), 1);
        frc_en[0] = 1'b0;
        issue(0, 4, 0, 3 + S);
        wait_drain();
        chk("sticky_cal_err", int'(cal_err), 1);

        // Reset mid-load: no done pulse, shadows back to init
        issue(4, 11, 0, 0);
        tick(2);
        reset_i = 1'b1;
        tick(2);
        chk("midrst_cal_err", int'(cal_err), 0);
        chk("midrst_init_done", int'(init_done), 0);
        chk("midrst_ready", int'(req_if.ready_o), 0);
        push_replay(0, 0, 0, 0, 0);
        reset_i = 1'b0;
        wait_drain();
        wait_init();
        chk("final_cal_err", int'(cal_err), 0);
        tick(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
